// File: rtl/morse_decoder.sv
// morse_decoder: synchronizes a hand-keyed Morse line and emits packed letter/space codes on a valid/ack handshake
module morse_decoder #(
  parameter int UNIT_TICKS = 4
) (
  input  logic       clock,
  input  logic       bReset,
  input  logic       key_in,
  input  logic       code_ack,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       overrun,
  output logic       busy
);
  localparam logic [8:0] DASH_T   = 9'(2 * UNIT_TICKS);
  localparam logic [8:0] LETTER_T = 9'(3 * UNIT_TICKS);
  localparam logic [8:0] WORD_T   = 9'(7 * UNIT_TICKS);
  typedef enum logic [1:0] {IDLE, MARK, SPACE, WORD} state_t;
  state_t state, state_nx;
  logic [1:0] sync;
  logic       key_s;
  logic [7:0] cnt, cnt_nx, cnt_inc;
  logic [8:0] run;
  logic [4:0] elems, elems_nx;
  logic [2:0] len, len_nx;
  logic       err, err_nx, dash, emit;
  logic [7:0] emit_code;
  assign key_s   = sync[1];
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  // run is the low/high run length including the sample taken on this edge
  assign run     = {1'b0, cnt} + 9'd1;
  assign dash    = {1'b0, cnt} >= DASH_T;
  assign busy    = (state == MARK) || (state == SPACE);
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    elems_nx  = elems;
    len_nx    = len;
    err_nx    = err;
    emit      = 1'b0;
    emit_code = 8'h00;
    case (state)
      IDLE: if (key_s) begin
        state_nx = MARK;
        cnt_nx   = 8'd1;
      end
      MARK: if (key_s) cnt_nx = cnt_inc;
      else begin
        state_nx = SPACE;
        cnt_nx   = 8'd1;
        err_nx   = err | (len == 3'd5);
        elems_nx = (len == 3'd5) ? elems : elems | (5'(dash) << len);
        len_nx   = (len == 3'd5) ? len : len + 3'd1;
      end
      SPACE: if (key_s) begin
        state_nx = MARK;
        cnt_nx   = 8'd1;
      end else begin
        cnt_nx = cnt_inc;
        if (run >= LETTER_T) begin
          emit      = 1'b1;
          emit_code = err ? 8'hE0 : {len, elems};
          elems_nx  = 5'd0;
          len_nx    = 3'd0;
          err_nx    = 1'b0;
          state_nx  = WORD;
        end
      end
      WORD: if (key_s) begin
        state_nx = MARK;
        cnt_nx   = 8'd1;
      end else begin
        cnt_nx = cnt_inc;
        if (run >= WORD_T) begin
          emit     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge bReset) begin
    if (!bReset) begin
      sync       <= 2'b00;
      state      <= IDLE;
      cnt        <= 8'd0;
      elems      <= 5'd0;
      len        <= 3'd0;
      err        <= 1'b0;
      code       <= 8'h00;
      code_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync  <= {sync[0], key_in};
      state <= state_nx;
      cnt   <= cnt_nx;
      elems <= elems_nx;
      len   <= len_nx;
      err   <= err_nx;
      if (emit) begin
        if (!code_valid || code_ack) begin
          code       <= emit_code;
          code_valid <= 1'b1;
        end else overrun <= 1'b1;
      end else if (code_ack && code_valid) begin
        code_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: drives keyed Morse streams and checks emitted codes and timing against a timing-rule model
module tb_morse_decoder;
  localparam int U = 4;
  logic clk = 1'b0, bReset = 1'b0, key_in = 1'b0, code_ack = 1'b0;
  logic [7:0] code;
  logic code_valid, overrun, busy;
  int cyc = 0, n_cmp = 0, n_err = 0;
  bit auto_ack = 1'b0;
  int seg[$], st[$], exp_cyc[$], obs_cyc[$];
  logic [7:0] exp_code[$], obs_code[$];
  morse_decoder #(.UNIT_TICKS(U)) dut (
    .clock(clk), .bReset(bReset), .key_in(key_in), .code_ack(code_ack),
    .code(code), .code_valid(code_valid), .overrun(overrun), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] got(input int i);
    return (i < obs_code.size()) ? obs_code[i] : 8'hxx;
  endfunction
  function automatic int got_cyc(input int i);
    return (i < obs_cyc.size()) ? obs_cyc[i] : -1000;
  endfunction
  // one clock of stimulus: observe outputs, then drive key and ack for the next edge
  task automatic step(input logic k, input logic ack);
    @(negedge clk);
    if (auto_ack && code_valid) begin
      obs_cyc.push_back(cyc);
      obs_code.push_back(code);
    end
    code_ack = ack | (auto_ack & code_valid);
    key_in = k;
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask
  // seg alternates mark/gap durations; the model derives codes and emit cycles from the timing rules
  task automatic play();
    int n, dashes;
    logic [7:0] c;
    n = 0;
    dashes = 0;
    st.delete(); obs_cyc.delete(); obs_code.delete(); exp_cyc.delete(); exp_code.delete();
    auto_ack = 1'b1;
    foreach (seg[k])
      for (int d = 0; d < seg[k]; d++) begin
        step((k % 2) == 0, 1'b0);
        if (d == 0) st.push_back(cyc);
      end
    for (int i = 0; i + 1 < seg.size(); i += 2) begin
      if (seg[i] >= 2 * U && n < 5) dashes += 1 << n;
      n++;
      if (seg[i+1] >= 3 * U) begin
        c = (n > 5) ? 8'hE0 : 8'(n * 32 + dashes);
        exp_cyc.push_back(st[i+1] + 3 * U + 2);
        exp_code.push_back(c);
        n = 0;
        dashes = 0;
        if (seg[i+1] >= 7 * U) begin
          exp_cyc.push_back(st[i+1] + 7 * U + 2);
          exp_code.push_back(8'h00);
        end
      end
    end
    check("n_codes", obs_code.size(), exp_code.size());
    for (int i = 0; i < exp_code.size() && i < obs_code.size(); i++) begin
      check("code", obs_code[i], exp_code[i]);
      check("emit_cyc", obs_cyc[i], exp_cyc[i]);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_code", code, 8'h00);
    check("rst_valid", code_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    bReset = 1'b1;
    seg = {7, 40, 8, 40};
    play();
    check("dot_7", got(0), 8'h20);
    check("dash_8", got(2), 8'h21);
    seg = {4, 4, 12, 36};
    play();
    check("A", got(0), 8'h42);
    check("A_latency", got_cyc(0) - st[3], 14);
    seg = {12, 4, 12, 4, 12, 36};
    play();
    check("O", got(0), 8'h67);
    seg = {4, 4, 4, 4, 4, 36};
    play();
    check("S", got(0), 8'h60);
    seg = {4, 40};
    play();
    check("E_space", got(1), 8'h00);
    check("space_latency", got_cyc(1) - st[1], 30);
    obs_code.delete();
    obs_cyc.delete();
    idle(40);
    check("idle_no_space", obs_code.size(), 0);
    seg = {4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 36};
    play();
    check("overflow", got(0), 8'hE0);
    auto_ack = 1'b0;
    repeat (4) step(1'b1, 1'b0);
    idle(20);
    check("E_held", code, 8'h20);
    check("E_valid", code_valid, 1'b1);
    check("E_no_overrun", overrun, 1'b0);
    repeat (12) step(1'b1, 1'b0);
    idle(20);
    check("ovr_code", code, 8'h20);
    check("ovr_flag", overrun, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("ack_valid", code_valid, 1'b0);
    check("ack_overrun", overrun, 1'b0);
    idle(12);
    check("space_code", code, 8'h00);
    check("space_valid", code_valid, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0);
    idle(20);
    repeat (12) step(1'b1, 1'b0);
    idle(13);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("simul_code", code, 8'h21);
    check("simul_valid", code_valid, 1'b1);
    check("simul_overrun", overrun, 1'b0);
    step(1'b0, 1'b1);
    idle(20);
    check("space_after_ack", code, 8'h00);
    check("space_after_ack_v", code_valid, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0);
    idle(20);
    repeat (4) step(1'b1, 1'b0);
    idle(4);
    repeat (4) step(1'b1, 1'b0);
    idle(5);
    check("mid_busy", busy, 1'b1);
    check("mid_valid", code_valid, 1'b1);
    #2 bReset = 1'b0;
    #1;
    check("mid_rst_code", code, 8'h00);
    check("mid_rst_valid", code_valid, 1'b0);
    check("mid_rst_overrun", overrun, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    idle(3);
    bReset = 1'b1;
    seg = {4, 36};
    play();
    check("post_rst_E", got(0), 8'h20);
    for (int r = 0; r < 8; r++) begin
      int nl, ne;
      seg.delete();
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++) begin
        ne = $urandom_range(1, 6);
        for (int e = 0; e < ne; e++) begin
          seg.push_back($urandom_range(1, 3 * U));
          if (e < ne - 1) seg.push_back($urandom_range(1, 3 * U - 1));
          else if (l < nl - 1) seg.push_back($urandom_range(3 * U, 9 * U));
          else seg.push_back(8 * U + 4);
        end
      end
      play();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/morse_decoder.md
# morse_decoder

Input peripheral that decodes a hand-keyed Morse line into packed 8-bit letter codes for the CPU. It synchronizes the key, measures mark and space durations in clock cycles, classifies each mark as a dot or a dash, and detects letter and word gaps. Each completed code is held on a valid/ack handshake until the control unit reads it onto the bus.

## Interface
- UNIT_TICKS, 4: clock cycles per Morse time unit (U). Legal range 1..36, which keeps 7U ≤ 255.
- clock  in  1  system clock; all state updates on the rising edge.
- bReset  in  1  asynchronous, active-low reset.
- key_in  in  1  raw Morse key, asynchronous, 1 = key down.
- code_ack  in  1  single-cycle strobe from control when `code` is latched from the bus.
- code  out  8  packed code: [7:5] length, [4:0] elements. Element i is bit i, first element is bit 0, 1 = dash.
- code_valid  out  1  `code` holds an unread entry.
- overrun  out  1  sticky; a completed code was dropped because the previous one was unread.
- busy  out  1  a letter is partially assembled (state MARK or SPACE).

## Operation
- **Synchronizer.** key_in passes through a 2-flop synchronizer (reset to 0) to give `key_s`. All decoding uses key_s and its previous value. An edge on key_in reaches key_s after 2 clocks.
- **Counter.** 8-bit run-length counter `cnt`. It saturates at 255 and never wraps.
- **Element accumulator.** 5-bit shift-in register `elems` plus a 3-bit element count `len`.
- **States:**
  - IDLE: no partial letter, word gap already reported or never started.
    - key_s rising → MARK, cnt=1.
  - MARK: while key_s=1, cnt++.
    - key_s falling → classify the mark using cnt (cycles high).
    - cnt < 2U → dot; cnt ≥ 2U → dash.
    - If len < 5: store the element at bit `len`, then len++.
    - If len = 5: set the error flag `err`.
    - Go to SPACE with cnt=1.
  - SPACE: while key_s=0, cnt++.
    - key_s rising before the low run reaches 3U → MARK, cnt=1 (same letter).
    - Low run reaches 3U → emit the letter, clear elems/len/err, go to WORD.
  - WORD: while key_s=0, cnt++.
    - key_s rising before 7U → MARK, cnt=1 (new letter, no space emitted).
    - Low run reaches 7U → emit the space code 0x00, go to IDLE.
- **Letter code.** {len[2:0], elems}. If err is set, the emitted code is 0xE0 (length 7 = error, elements zero).
- **Emit and handshake:**
  - code_valid=0 at emit: load `code`, set code_valid.
  - code_valid=1 and code_ack=0 at emit: discard the new code, set overrun, keep the old `code`.
  - code_valid=1 and code_ack=1 at emit: load the new code, code_valid stays 1, overrun unchanged.
  - code_ack with no emit: clear code_valid and overrun.
  - code_ack while code_valid=0: ignored.
- The space code is emitted only after at least one letter since the last space. IDLE never emits.

## Timing
- **Reset values.** Asserting bReset (low) forces immediately: code=0x00, code_valid=0, overrun=0, busy=0, state IDLE, cnt=0, elems=0, len=0, err=0, synchronizer=0. Any partial letter is discarded and nothing is emitted.
- **Key held at reset release.** If key_in is high when reset deasserts, it is seen as a rising edge 2 cycles later.
- **Letter latency.** code_valid rises on the edge where the synchronized low run reaches 3U cycles. That is 3U+2 clocks after key_in falls.
- **Space latency.** The space code is emitted 7U+2 clocks after the last key_in fall.
- **Ack latency.** code_valid falls on the clock edge that samples code_ack=1.
- **busy.** High in MARK and SPACE, low in IDLE and WORD. It changes on the same edge as the state.

## Test plan
- **Dot/dash boundary (U=4).** Key high 7 cycles, low 20 → code 0x20 (length 1, dot). Then key high 8 cycles, low 20 → code 0x21 (dash).
- **Letter assembly.** "A" = dot(4), gap 4, dash(12), low 12 → 0x42, code_valid rising exactly 14 clocks after the last key_in fall. "O" = three dashes → 0x67. "S" = three dots → 0x60. Ack each code.
- **Word gap.** "E" followed by 40 low cycles, acked → 0x20, then 0x00 at 30 clocks after the key fall. Next gap ≥ 28 in IDLE → no second 0x00.
- **Overflow.** Six dots with gaps of 4 → single code 0xE0.
- **Overrun and simultaneous ack.**
  - "E" left unacked, then "T" → code stays 0x20 and overrun=1. Ack → code_valid=0, overrun=0.
  - Repeat with ack asserted on the emit cycle of "T" → code=0x21, code_valid=1, overrun=0.
- **Reset mid-letter.** Send two dots, assert bReset in the SPACE state → all outputs zero at once. Release and send "E" → only 0x20 is emitted.
